// File: rtl/vga_pixel_output.sv
`default_nettype none
// ============================================================================
// Module   : vga_pixel_output
// Brief    : VGA/DVI raster timing with RGB565-pair FIFO consumer and RGB888 out
// Revision : 1.0
// ============================================================================
module vga_pixel_output #(
  parameter int unsigned H_ACTIVE  = 640,
  parameter int unsigned H_FP      = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BP      = 48,
  parameter int unsigned V_ACTIVE  = 480,
  parameter int unsigned V_FP      = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BP      = 33,
  parameter bit          HSYNC_POL = 1'b0,
  parameter bit          VSYNC_POL = 1'b0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        enable_i,
  input  logic [31:0] data_in_i,
  input  logic        valid_i,
  output logic        pop_o,
  input  logic        underrun_clr_i,
  output logic [7:0]  vga_r_o,
  output logic [7:0]  vga_g_o,
  output logic [7:0]  vga_b_o,
  output logic        hsync_o,
  output logic        vsync_o,
  output logic        de_o,
  output logic        frame_start_o,
  output logic        underrun_o
);

  localparam logic [11:0] c_h_active = 12'(H_ACTIVE);
  localparam logic [11:0] c_h_last   = 12'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [11:0] c_hs_start = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] c_hs_end   = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] c_v_active = 12'(V_ACTIVE);
  localparam logic [11:0] c_v_last   = 12'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [11:0] c_vs_start = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] c_vs_end   = 12'(V_ACTIVE + V_FP + V_SYNC);

  logic [11:0] h_cnt_q, h_cnt_d;
  logic [11:0] v_cnt_q, v_cnt_d;
  logic        miss_q;
  logic        de_q, hsync_q, vsync_q, frame_start_q, underrun_q;
  logic [7:0]  vga_r_q, vga_g_q, vga_b_q;

  logic        w_active, w_hs, w_vs, w_run_active, w_miss_now, w_blank;
  logic [15:0] w_pix;

  always_comb begin
    w_active     = (h_cnt_q < c_h_active) && (v_cnt_q < c_v_active);
    w_hs         = (h_cnt_q >= c_hs_start) && (h_cnt_q < c_hs_end);
    w_vs         = (v_cnt_q >= c_vs_start) && (v_cnt_q < c_vs_end);
    w_run_active = enable_i && w_active;
    w_miss_now   = w_run_active && !h_cnt_q[0] && !valid_i;
    // A pair that missed at its even pixel stays black and is never popped.
    pop_o        = w_run_active && h_cnt_q[0] && valid_i && !miss_q;
    w_pix        = h_cnt_q[0] ? data_in_i[31:16] : data_in_i[15:0];
    w_blank      = !w_run_active || !valid_i || (h_cnt_q[0] && miss_q);

    h_cnt_d = h_cnt_q + 12'd1;
    v_cnt_d = v_cnt_q;
    if (!enable_i) begin
      h_cnt_d = 12'd0;
      v_cnt_d = 12'd0;
    end else if (h_cnt_q == c_h_last) begin
      h_cnt_d = 12'd0;
      v_cnt_d = (v_cnt_q == c_v_last) ? 12'd0 : v_cnt_q + 12'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      h_cnt_q       <= 12'd0;
      v_cnt_q       <= 12'd0;
      miss_q        <= 1'b0;
      de_q          <= 1'b0;
      hsync_q       <= !HSYNC_POL;
      vsync_q       <= !VSYNC_POL;
      frame_start_q <= 1'b0;
      underrun_q    <= 1'b0;
      vga_r_q       <= 8'd0;
      vga_g_q       <= 8'd0;
      vga_b_q       <= 8'd0;
    end else begin
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      de_q          <= w_run_active;
      hsync_q       <= (enable_i && w_hs) ? HSYNC_POL : !HSYNC_POL;
      vsync_q       <= (enable_i && w_vs) ? VSYNC_POL : !VSYNC_POL;
      frame_start_q <= enable_i && (h_cnt_q == 12'd0) && (v_cnt_q == 12'd0);
      if (!enable_i) begin
        miss_q <= 1'b0;
      end else if (w_active && !h_cnt_q[0]) begin
        miss_q <= !valid_i;
      end
      if (w_miss_now) begin
        underrun_q <= 1'b1;
      end else if (underrun_clr_i) begin
        underrun_q <= 1'b0;
      end
      if (w_blank) begin
        vga_r_q <= 8'd0;
        vga_g_q <= 8'd0;
        vga_b_q <= 8'd0;
      end else begin
        vga_r_q <= {w_pix[15:11], w_pix[15:13]};
        vga_g_q <= {w_pix[10:5], w_pix[10:9]};
        vga_b_q <= {w_pix[4:0], w_pix[4:2]};
      end
    end
  end

  assign de_o          = de_q;
  assign hsync_o       = hsync_q;
  assign vsync_o       = vsync_q;
  assign frame_start_o = frame_start_q;
  assign underrun_o    = underrun_q;
  assign vga_r_o       = vga_r_q;
  assign vga_g_o       = vga_g_q;
  assign vga_b_o       = vga_b_q;

endmodule
`default_nettype wire
